mips_program_encoder: RTL and testbench

- Program-load block that produces the instruction words consumed by the single-cycle control and datapath, so it runs in the opposite direction to the opcode decoder.
- Accepts symbolic instruction fields over a valid/ready stream and encodes each into a 32-bit MIPS word (R, I or J format).
- Writes the words into instruction memory at consecutive word addresses through a 2-entry output buffer, with memory-side backpressure.
- Supported opcode set: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ORI 001101, ADDI 001000, ADDIU 001001, ANDI 001100, LUI 001111, SLTI 001010, SLTIU 001011, XORI 001110.

---
 rtl/mips_program_encoder.sv | 215 +++++++++++++++++++++
 tb/tb_mips_program_encoder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_program_encoder.sv
// mips_program_encoder: loads a program into instruction memory.
// Symbolic instruction fields arrive on a valid/ready stream. Each one is
// encoded into a 32-bit MIPS word and written to consecutive word addresses
// through a 2-entry buffer that absorbs memory backpressure.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_start, i_start_addr  open a session at a base byte address
//   i_in_*, o_in_ready     instruction field stream (valid/ready, last)
//   o_mem_*, i_mem_ready   memory write port (strobe, address, data, ready)
//   o_count                words written this session (saturating)
//   o_busy, o_done         LOAD and DONE state flags
//   o_error                sticky flag for an unsupported opcode
module mips_program_encoder #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_INSTR = 256,
  localparam int unsigned CNT_W    = $clog2(MAX_INSTR) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_last,
  input  logic [5:0]        i_in_opcode,
  input  logic [4:0]        i_in_rs,
  input  logic [4:0]        i_in_rt,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_shamt,
  input  logic [5:0]        i_in_funct,
  input  logic [15:0]       i_in_imm,
  input  logic [25:0]       i_in_target,
  output logic              o_mem_wr_en,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wr_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_accepted;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  // Shift-style buffer: entry 0 is the head presented to memory.
  logic              r_v0;
  logic              r_v1;
  logic [31:0]       r_b0;
  logic [31:0]       r_b1;

  logic [31:0]       w_word;
  logic              w_supported;
  logic              w_pop;
  logic              w_room;
  logic              w_below_max;
  logic              w_in_ready;
  logic              w_xfer;
  logic              w_push;
  logic              w_v0_n;
  logic              w_v1_n;
  logic [31:0]       w_b0_n;
  logic [31:0]       w_b1_n;

  // Field-to-word encoder; unknown opcodes flag w_supported low.
  always_comb begin
    w_supported = 1'b1;
    w_word      = '0;
    case (i_in_opcode)
      OP_RTYPE: w_word = {i_in_opcode, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, i_in_funct};
      OP_J:     w_word = {i_in_opcode, i_in_target};
      OP_LUI:   w_word = {i_in_opcode, 5'b00000, i_in_rt, i_in_imm};
      OP_LW, OP_SW, OP_BEQ, OP_ORI, OP_ADDI, OP_ADDIU, OP_ANDI,
      OP_SLTI, OP_SLTIU, OP_XORI:
                w_word = {i_in_opcode, i_in_rs, i_in_rt, i_in_imm};
      default:  w_supported = 1'b0;
    endcase
  end

  // Ready accounts for a same-cycle pop so a full buffer can still stream.
  assign w_pop       = r_v0 && i_mem_ready;
  assign w_room      = !r_v1 || w_pop;
  assign w_below_max = r_accepted < CNT_W'(MAX_INSTR);
  assign w_in_ready  = (r_state == S_LOAD) && w_room && w_below_max;
  assign w_xfer      = i_in_valid && w_in_ready;
  assign w_push      = w_xfer && w_supported;

  // Next buffer contents: pop shifts entry 1 forward, push fills first free slot.
  always_comb begin
    w_v0_n = r_v0;
    w_v1_n = r_v1;
    w_b0_n = r_b0;
    w_b1_n = r_b1;
    if (w_pop) begin
      w_v0_n = r_v1;
      w_b0_n = r_b1;
      w_v1_n = 1'b0;
    end
    if (w_push) begin
      if (w_v0_n) begin
        w_v1_n = 1'b1;
        w_b1_n = w_word;
      end else begin
        w_v0_n = 1'b1;
        w_b0_n = w_word;
      end
    end
  end

  // Session FSM, buffer, address pointer and counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_accepted <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_b0       <= '0;
      r_b1       <= '0;
    end else begin
      r_v0 <= w_v0_n;
      r_v1 <= w_v1_n;
      r_b0 <= w_b0_n;
      r_b1 <= w_b1_n;

      if (w_pop) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(4);
        if (r_count < CNT_W'(MAX_INSTR)) begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      if (w_xfer) begin
        r_accepted <= r_accepted + CNT_W'(1);
        if (!w_supported) begin
          r_error <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_wr_ptr   <= i_start_addr & ~ADDR_W'(3);
            r_count    <= '0;
            r_accepted <= '0;
            r_error    <= 1'b0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_xfer && (i_in_last || (r_accepted == CNT_W'(MAX_INSTR - 1)))) begin
            r_state <= S_DRAIN;
            r_busy  <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Pushes only happen in LOAD, so an empty head means nothing is pending.
          if (!r_v0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready    = w_in_ready;
  assign o_mem_wr_en   = r_v0;
  assign o_mem_addr    = r_wr_ptr;
  assign o_mem_wr_data = r_b0;
  assign o_count       = r_count;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: tb/tb_mips_program_encoder.sv
// Directed bench for mips_program_encoder: a default-size instance for the
// encoding, buffering, error and wrap scenarios, and a MAX_INSTR=4 instance
// for the session-limit scenario.
module tb_mips_program_encoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_start = 1'b0;
  logic [31:0] start_addr = '0;
  logic        in_valid = 1'b0;
  logic        s_in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [5:0]  in_opcode = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        mem_ready = 1'b1;

  logic        in_ready, mem_wr_en, busy, done, error;
  logic [31:0] mem_addr, mem_wr_data;
  logic [8:0]  count;

  logic        s_in_ready, s_mem_wr_en, s_busy, s_done, s_error;
  logic [31:0] s_mem_addr, s_mem_wr_data;
  logic [2:0]  s_count;

  int checks = 0;
  int errors = 0;

  mips_program_encoder #(.ADDR_W(32), .MAX_INSTR(256)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_addr(start_addr),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_last(in_last),
    .i_in_opcode(in_opcode), .i_in_rs(in_rs), .i_in_rt(in_rt), .i_in_rd(in_rd),
    .i_in_shamt(in_shamt), .i_in_funct(in_funct), .i_in_imm(in_imm),
    .i_in_target(in_target), .o_mem_wr_en(mem_wr_en), .i_mem_ready(mem_ready),
    .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wr_data), .o_count(count),
    .o_busy(busy), .o_done(done), .o_error(error)
  );

  mips_program_encoder #(.ADDR_W(32), .MAX_INSTR(4)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_start_addr(start_addr),
    .i_in_valid(s_in_valid), .o_in_ready(s_in_ready), .i_in_last(in_last),
    .i_in_opcode(in_opcode), .i_in_rs(in_rs), .i_in_rt(in_rt), .i_in_rd(in_rd),
    .i_in_shamt(in_shamt), .i_in_funct(in_funct), .i_in_imm(in_imm),
    .i_in_target(in_target), .o_mem_wr_en(s_mem_wr_en), .i_mem_ready(mem_ready),
    .o_mem_addr(s_mem_addr), .o_mem_wr_data(s_mem_wr_data), .o_count(s_count),
    .o_busy(s_busy), .o_done(s_done), .o_error(s_error)
  );

  // Write monitor: records completed writes, counts strobe cycles.
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wr_en_cycles = 0;
  logic [31:0] s_last_data = '0;
  always @(negedge clk) begin
    if (!rst && mem_wr_en) wr_en_cycles <= wr_en_cycles + 1;
    if (!rst && mem_wr_en && mem_ready) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wr_data);
    end
    if (!rst && s_mem_wr_en && mem_ready) s_last_data <= s_mem_wr_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt; in_last = last;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic handshake();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    drive(op, rs, rt, rd, sh, fn, imm, tgt, last);
    in_valid = 1'b1;
    handshake();
  endtask

  task automatic start_session(input logic [31:0] addr);
    start = 1'b1;
    start_addr = addr;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done_timeout done=%0b required=1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if ({in_ready, mem_wr_en, busy, done, error} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, mem_wr_en, busy, done, error});
    end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++;
    if (mem_wr_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", mem_wr_data); end
    checks++;
    if (count !== 9'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int base;
    base = wq_data.size();
    mem_ready = 1'b1;
    start_session(32'h0040_0003);
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++;
    send(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    // Word sits in the buffer one cycle after its transfer.
    if (mem_wr_en !== 1'b1 || mem_wr_data !== 32'h2022_FFFF || mem_addr !== 32'h0040_0000) begin
      errors++;
      $display("FAIL basic_latency got en=%b data=%h addr=%h exp en=1 data=2022ffff addr=00400000",
               mem_wr_en, mem_wr_data, mem_addr);
    end
    checks++;
    repeat (2) @(posedge clk);
    #1;
    if (wq_data.size() - base !== 1) begin errors++; $display("FAIL basic_nwrites got=%0d exp=1", wq_data.size() - base); end
    checks++;
    if (wq_addr[base] !== 32'h0040_0000 || wq_data[base] !== 32'h2022_FFFF) begin
      errors++; $display("FAIL basic_write0 got addr=%h data=%h exp 00400000 2022ffff", wq_addr[base], wq_data[base]);
    end
    checks++;
    if (count !== 9'd1) begin errors++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    checks++;
    send(6'b001101, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b1);
    wait_done();
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_done got done=%b busy=%b rdy=%b exp 1 0 0", done, busy, in_ready);
    end
    checks++;
    if (wq_addr[base+1] !== 32'h0040_0004 || wq_data[base+1] !== 32'h3401_0001 || count !== 9'd2) begin
      errors++; $display("FAIL basic_write1 got addr=%h data=%h cnt=%0d exp 00400004 34010001 2",
                         wq_addr[base+1], wq_data[base+1], count);
    end
    checks++;
  endtask

  task automatic test_rtype_j();
    int base;
    base = wq_data.size();
    start_session(32'h0000_1000);
    send(6'b000000, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20, 16'h0, 26'd0, 1'b0);
    send(6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h010_0000, 1'b1);
    wait_done();
    if (wq_data.size() - base !== 2) begin errors++; $display("FAIL rj_nwrites got=%0d exp=2", wq_data.size() - base); end
    checks++;
    if (wq_addr[base] !== 32'h0000_1000 || wq_data[base] !== 32'h0064_2820) begin
      errors++; $display("FAIL rj_rtype got addr=%h data=%h exp 00001000 00642820", wq_addr[base], wq_data[base]);
    end
    checks++;
    if (wq_addr[base+1] !== 32'h0000_1004 || wq_data[base+1] !== 32'h0810_0000) begin
      errors++; $display("FAIL rj_jump got addr=%h data=%h exp 00001004 08100000", wq_addr[base+1], wq_data[base+1]);
    end
    checks++;
  endtask

  task automatic test_lui();
    int base;
    base = wq_data.size();
    start_session(32'h0000_2000);
    send(6'b001111, 5'd7, 5'd8, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b1);
    wait_done();
    if (wq_data[base] !== 32'h3C08_1234) begin
      errors++; $display("FAIL lui_word got=%h exp=3c081234", wq_data[base]);
    end
    checks++;
  endtask

  task automatic test_error();
    int base;
    base = wq_data.size();
    start_session(32'h0000_3000);
    send(6'b001101, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0011, 26'd0, 1'b0);
    if (error !== 1'b0) begin errors++; $display("FAIL err_before got=%b exp=0", error); end
    checks++;
    send(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'hDEAD, 26'd0, 1'b0);
    if (error !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", error); end
    checks++;
    send(6'b001101, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0022, 26'd0, 1'b1);
    wait_done();
    if (wq_data.size() - base !== 2 || count !== 9'd2) begin
      errors++; $display("FAIL err_nwrites got=%0d cnt=%0d exp 2 2", wq_data.size() - base, count);
    end
    checks++;
    if (wq_addr[base] !== 32'h0000_3000 || wq_data[base] !== 32'h3422_0011 ||
        wq_addr[base+1] !== 32'h0000_3004 || wq_data[base+1] !== 32'h3464_0022) begin
      errors++; $display("FAIL err_words got %h:%h %h:%h exp 00003000:34220011 00003004:34640022",
                         wq_addr[base], wq_data[base], wq_addr[base+1], wq_data[base+1]);
    end
    checks++;
    if (error !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL err_sticky got err=%b done=%b exp 1 1", error, done);
    end
    checks++;
    start_session(32'h0000_4000);
    if (error !== 1'b0 || count !== 9'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL err_clear got err=%b cnt=%0d busy=%b exp 0 0 1", error, count, busy);
    end
    checks++;
    send(6'b001101, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'd0, 1'b1);
    wait_done();
  endtask

  task automatic test_backpressure();
    int base;
    base = wq_data.size();
    mem_ready = 1'b0;
    start_session(32'h0000_5000);
    send(6'b001001, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
    send(6'b001100, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0);
    drive(6'b001110, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0F0F, 26'd0, 1'b1);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
      checks++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 32'h0000_5000 || mem_wr_data !== 32'h2421_0001) begin
        errors++; $display("FAIL bp_hold got en=%b addr=%h data=%h exp 1 00005000 24210001",
                           mem_wr_en, mem_addr, mem_wr_data);
      end
      checks++;
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    handshake();
    wait_done();
    if (wq_data.size() - base !== 3 || count !== 9'd3) begin
      errors++; $display("FAIL bp_nwrites got=%0d cnt=%0d exp 3 3", wq_data.size() - base, count);
    end
    checks++;
    if (wq_data[base] !== 32'h2421_0001 || wq_data[base+1] !== 32'h3042_00FF || wq_data[base+2] !== 32'h3863_0F0F) begin
      errors++; $display("FAIL bp_order got %h %h %h exp 24210001 304200ff 38630f0f",
                         wq_data[base], wq_data[base+1], wq_data[base+2]);
    end
    checks++;
    if (wq_addr[base+1] !== 32'h0000_5004 || wq_addr[base+2] !== 32'h0000_5008) begin
      errors++; $display("FAIL bp_addr got %h %h exp 00005004 00005008", wq_addr[base+1], wq_addr[base+2]);
    end
    checks++;
  endtask

  task automatic test_wrap();
    int base;
    base = wq_data.size();
    start_session(32'hFFFF_FFFC);
    send(6'b001010, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h8000, 26'd0, 1'b0);
    send(6'b001011, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h7FFF, 26'd0, 1'b1);
    wait_done();
    if (wq_addr[base] !== 32'hFFFF_FFFC || wq_addr[base+1] !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_addr got %h %h exp fffffffc 00000000", wq_addr[base], wq_addr[base+1]);
    end
    checks++;
    if (wq_data[base] !== 32'h2822_8000 || wq_data[base+1] !== 32'h2C22_7FFF || error !== 1'b0) begin
      errors++; $display("FAIL wrap_data got %h %h err=%b exp 28228000 2c227fff 0",
                         wq_data[base], wq_data[base+1], error);
    end
    checks++;
  endtask

  task automatic test_max();
    int acc;
    int n;
    acc = 0;
    mem_ready = 1'b1;
    start_addr = 32'h0000_0100;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(6'b001101, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'(k), 26'd0, 1'b0);
      s_in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_in_ready && n < 8) begin
        @(negedge clk);
        n++;
      end
      if (s_in_ready) acc++;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
    end
    if (acc !== 4) begin errors++; $display("FAIL max_accepted got=%0d exp=4", acc); end
    checks++;
    if (s_done !== 1'b1 || s_busy !== 1'b0 || s_count !== 3'd4 || s_error !== 1'b0) begin
      errors++; $display("FAIL max_state got done=%b busy=%b cnt=%0d err=%b exp 1 0 4 0",
                         s_done, s_busy, s_count, s_error);
    end
    checks++;
    if (s_mem_addr !== 32'h0000_0110 || s_mem_wr_en !== 1'b0 || s_last_data !== 32'h3401_0003) begin
      errors++; $display("FAIL max_writes got addr=%h en=%b last=%h exp 00000110 0 34010003",
                         s_mem_addr, s_mem_wr_en, s_last_data);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int ecyc;
    mem_ready = 1'b0;
    start_session(32'h0000_6000);
    send(6'b001101, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0AAA, 26'd0, 1'b0);
    send(6'b001101, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0BBB, 26'd0, 1'b0);
    ecyc = wr_en_cycles;
    #2;
    rst = 1'b1;
    #1;
    if ({in_ready, mem_wr_en, busy, done, error} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wr_data !== 32'h0 || count !== 9'd0) begin
      errors++; $display("FAIL midrst_async got flags=%b addr=%h data=%h cnt=%0d exp all 0",
                         {in_ready, mem_wr_en, busy, done, error}, mem_addr, mem_wr_data, count);
    end
    checks++;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    if (wr_en_cycles !== ecyc || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_nowrite got strobes=%0d busy=%b done=%b exp %0d 0 0",
                         wr_en_cycles - ecyc, busy, done, 0);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rtype_j();
    test_lui();
    test_error();
    test_backpressure();
    test_wrap();
    test_max();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
